// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one line-granular pmem port between I-cache and D-cache.
// The granted requester is forwarded to memory unchanged and alone sees the response.
module cache_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned LINE_W = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic              i_write,
   input  logic [ADDR_W-1:0] i_address,
   input  logic [LINE_W-1:0] i_wdata,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_resp,
   output logic [15:0]       i_grant_cnt,
   output logic [15:0]       d_grant_cnt
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] SERVE_I = 2'd1;
   localparam logic [1:0] SERVE_D = 2'd2;

   logic [1:0] state;
   logic [1:0] next_state;
   logic       last;
   logic       mask_i;
   logic       mask_d;
   logic       ereq_i;
   logic       ereq_d;

   assign ereq_i = (i_read | i_write) & ~mask_i;
   assign ereq_d = (d_read | d_write) & ~mask_d;

   // State, round-robin history, post-completion masks and grant counters
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         last        <= 1'b1;
         mask_i      <= 1'b0;
         mask_d      <= 1'b0;
         i_grant_cnt <= 16'd0;
         d_grant_cnt <= 16'd0;
      end else begin
         state <= next_state;
         case (state)
            IDLE: begin
               mask_i <= 1'b0;
               mask_d <= 1'b0;
            end
            SERVE_I: begin
               if (mem_resp) begin
                  mask_i      <= 1'b1;
                  last        <= 1'b0;
                  i_grant_cnt <= i_grant_cnt + 16'd1;
               end
            end
            SERVE_D: begin
               if (mem_resp) begin
                  mask_d      <= 1'b1;
                  last        <= 1'b1;
                  d_grant_cnt <= d_grant_cnt + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Next-state selection and request/response steering
   always_comb begin
      next_state  = state;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_address = '0;
      mem_wdata   = '0;
      i_resp      = 1'b0;
      d_resp      = 1'b0;
      i_rdata     = '0;
      d_rdata     = '0;
      case (state)
         IDLE: begin
            if (ereq_i && ereq_d) next_state = last ? SERVE_I : SERVE_D;
            else if (ereq_i)      next_state = SERVE_I;
            else if (ereq_d)      next_state = SERVE_D;
         end
         SERVE_I: begin
            mem_read    = i_read;
            mem_write   = i_write;
            mem_address = i_address;
            mem_wdata   = i_wdata;
            i_resp      = mem_resp;
            i_rdata     = mem_rdata;
            d_rdata     = mem_rdata;
            if (mem_resp) next_state = IDLE;
         end
         SERVE_D: begin
            mem_read    = d_read;
            mem_write   = d_write;
            mem_address = d_address;
            mem_wdata   = d_wdata;
            d_resp      = mem_resp;
            i_rdata     = mem_rdata;
            d_rdata     = mem_rdata;
            if (mem_resp) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: drivers queue expected transactions per cache,
// a negedge monitor checks every delivered response against them.
module tb_cache_arbiter;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned LINE_W = 256;
   localparam int LAT = 5;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              i_read = 1'b0, i_write = 1'b0;
   logic [ADDR_W-1:0] i_address = '0;
   logic [LINE_W-1:0] i_wdata = '0;
   logic [LINE_W-1:0] i_rdata;
   logic              i_resp;
   logic              d_read = 1'b0, d_write = 1'b0;
   logic [ADDR_W-1:0] d_address = '0;
   logic [LINE_W-1:0] d_wdata = '0;
   logic [LINE_W-1:0] d_rdata;
   logic              d_resp;
   logic              mem_read, mem_write;
   logic [ADDR_W-1:0] mem_address;
   logic [LINE_W-1:0] mem_wdata;
   logic [LINE_W-1:0] mem_rdata;
   logic              mem_resp;
   logic [15:0]       i_grant_cnt, d_grant_cnt;

   typedef struct {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [LINE_W-1:0] wdata;
      logic [LINE_W-1:0] rdata;
   } exp_t;

   exp_t exp_i[$];
   exp_t exp_d[$];
   int   grant_log[$];
   int   n_cmp = 0;
   int   n_err = 0;

   cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
      .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
   );

   always #5 clk = ~clk;

   // Memory model: fixed latency, one-cycle resp, data derived from the address
   int mem_cnt;
   assign mem_rdata = (mem_address == 32'h0000_1000) ? {32{8'hA5}} : {8{mem_address}};
   always @(posedge clk) begin
      if (!rst) begin
         mem_cnt  <= 0;
         mem_resp <= 1'b0;
      end else if (mem_resp) begin
         mem_resp <= 1'b0;
         mem_cnt  <= 0;
      end else if (mem_read | mem_write) begin
         if (mem_cnt == LAT - 1) mem_resp <= 1'b1;
         else                    mem_cnt  <= mem_cnt + 1;
      end
   end

   task automatic check(input string name, input logic [LINE_W-1:0] act,
                        input logic [LINE_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_txn(input string who, input exp_t e);
      check({who, " mem_write"}, LINE_W'(mem_write), LINE_W'(e.wr));
      check({who, " mem_read"}, LINE_W'(mem_read), LINE_W'(!e.wr));
      check({who, " mem_address"}, LINE_W'(mem_address), LINE_W'(e.addr));
      if (e.wr) check({who, " mem_wdata"}, mem_wdata, e.wdata);
      else      check({who, " rdata"}, (who == "I") ? i_rdata : d_rdata, e.rdata);
   endtask

   // Monitor: every delivered response must match the head of that cache's queue
   always @(negedge clk) begin
      if (rst && (i_resp || d_resp)) begin
         check("resp exclusive", LINE_W'(i_resp & d_resp), '0);
         if (i_resp) begin
            if (exp_i.size() == 0) check("unexpected i_resp", LINE_W'(1), LINE_W'(0));
            else begin
               check_txn("I", exp_i.pop_front());
               grant_log.push_back(0);
            end
         end
         if (d_resp) begin
            if (exp_d.size() == 0) check("unexpected d_resp", LINE_W'(1), LINE_W'(0));
            else begin
               check_txn("D", exp_d.pop_front());
               grant_log.push_back(1);
            end
         end
      end
   end

   task automatic issue(input bit is_d, input bit wr, input logic [ADDR_W-1:0] addr,
                        input logic [LINE_W-1:0] wdata, input logic [LINE_W-1:0] rdata);
      exp_t e;
      e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
      if (is_d) begin
         exp_d.push_back(e);
         d_read = !wr; d_write = wr; d_address = addr; d_wdata = wdata;
      end else begin
         exp_i.push_back(e);
         i_read = !wr; i_write = wr; i_address = addr; i_wdata = wdata;
      end
   endtask

   // Wait for this cache's resp, then drop strobes in the following cycle unless keep
   task automatic wait_resp(input bit is_d, input bit keep);
      bit seen = 1'b0;
      for (int k = 0; k < 200 && !seen; k++) begin
         @(negedge clk);
         seen = is_d ? d_resp : i_resp;
      end
      check(is_d ? "d_resp timeout" : "i_resp timeout", LINE_W'(seen), LINE_W'(1));
      @(posedge clk); #1;
      if (!keep) begin
         if (is_d) begin d_read = 1'b0; d_write = 1'b0; end
         else      begin i_read = 1'b0; i_write = 1'b0; end
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " mem_read"}, LINE_W'(mem_read), '0);
      check({tag, " mem_write"}, LINE_W'(mem_write), '0);
      check({tag, " mem_address"}, LINE_W'(mem_address), '0);
      check({tag, " mem_wdata"}, mem_wdata, '0);
      check({tag, " i_resp"}, LINE_W'(i_resp), '0);
      check({tag, " d_resp"}, LINE_W'(d_resp), '0);
      check({tag, " i_rdata"}, i_rdata, '0);
      check({tag, " d_rdata"}, d_rdata, '0);
      check({tag, " i_grant_cnt"}, LINE_W'(i_grant_cnt), '0);
      check({tag, " d_grant_cnt"}, LINE_W'(d_grant_cnt), '0);
   endtask

   initial begin
      bit busy;
      // Reset values
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check_idle_outputs("reset");
      repeat (3) @(negedge clk);
      check_idle_outputs("reset idle");

      // Single I read
      @(posedge clk); #1;
      issue(0, 0, 32'h0000_1000, '0, {32{8'hA5}});
      @(negedge clk);
      check("t1 arb latency", LINE_W'(mem_read), '0);
      @(negedge clk);
      check("t1 mem_read", LINE_W'(mem_read), LINE_W'(1));
      check("t1 mem_address", LINE_W'(mem_address), LINE_W'(32'h0000_1000));
      wait_resp(0, 0);
      check("t1 i_grant_cnt", LINE_W'(i_grant_cnt), LINE_W'(1));
      check("t1 d_grant_cnt", LINE_W'(d_grant_cnt), '0);

      // Simultaneous requests after reset: I first, D granted at R+2
      do_reset();
      grant_log.delete();
      issue(0, 0, 32'h0000_3000, '0, {8{32'h0000_3000}});
      issue(1, 1, 32'h0000_2000, LINE_W'(32'hDEAD_BEEF), '0);
      wait_resp(0, 0);
      @(negedge clk);
      check("t2 idle gap", LINE_W'(mem_write | mem_read), '0);
      @(negedge clk);
      check("t2 d mem_write", LINE_W'(mem_write), LINE_W'(1));
      check("t2 d mem_address", LINE_W'(mem_address), LINE_W'(32'h0000_2000));
      check("t2 d mem_wdata", mem_wdata, LINE_W'(32'hDEAD_BEEF));
      wait_resp(1, 0);
      check("t2 order", LINE_W'(grant_log.size() == 2 && grant_log[0] == 0 && grant_log[1] == 1),
            LINE_W'(1));
      check("t2 i_grant_cnt", LINE_W'(i_grant_cnt), LINE_W'(1));
      check("t2 d_grant_cnt", LINE_W'(d_grant_cnt), LINE_W'(1));

      // Continuous contention: strict alternation
      do_reset();
      grant_log.delete();
      fork
         begin
            for (int n = 0; n < 4; n++) begin
               issue(0, 0, ADDR_W'(32'h0001_0000 + n * 32), '0,
                     {8{ADDR_W'(32'h0001_0000 + n * 32)}});
               wait_resp(0, 1);
            end
            i_read = 1'b0;
         end
         begin
            for (int n = 0; n < 4; n++) begin
               issue(1, n[0], ADDR_W'(32'h0002_0000 + n * 32), LINE_W'(n + 7),
                     {8{ADDR_W'(32'h0002_0000 + n * 32)}});
               wait_resp(1, 1);
            end
            d_read = 1'b0; d_write = 1'b0;
         end
      join
      check("t3 grant count", LINE_W'(grant_log.size()), LINE_W'(8));
      for (int n = 0; n < 8 && n < grant_log.size(); n++)
         check($sformatf("t3 grant %0d", n), LINE_W'(grant_log[n]), LINE_W'(n % 2));
      check("t3 i_grant_cnt", LINE_W'(i_grant_cnt), LINE_W'(4));
      check("t3 d_grant_cnt", LINE_W'(d_grant_cnt), LINE_W'(4));

      // Stale strobe held one cycle after resp must not be re-granted
      do_reset();
      issue(0, 0, 32'h0000_4000, '0, {8{32'h0000_4000}});
      wait_resp(0, 1);
      @(posedge clk); #1 i_read = 1'b0;
      busy = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (mem_read | mem_write) busy = 1'b1;
      end
      check("t4 no regrant", LINE_W'(busy), '0);
      check("t4 i_grant_cnt", LINE_W'(i_grant_cnt), LINE_W'(1));

      // Reset while serving D, then D re-granted
      @(posedge clk); #1;
      d_read = 1'b1; d_address = 32'h0000_5000;
      repeat (2) @(negedge clk);
      check("t5 serving d", LINE_W'(mem_read), LINE_W'(1));
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check_idle_outputs("t5 reset");
      @(posedge clk); #1 rst = 1'b1;
      issue(1, 0, 32'h0000_5000, '0, {8{32'h0000_5000}});
      wait_resp(1, 0);
      check("t5 d_grant_cnt", LINE_W'(d_grant_cnt), LINE_W'(1));

      repeat (3) @(negedge clk);
      check("queues drained", LINE_W'(exp_i.size() + exp_d.size()), '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Shares the single physical-memory port between the instruction cache and the data cache. Each cache presents its normal line-granular pmem interface: read or write strobe, address, and 256-bit line data. The arbiter grants one requester at a time with round-robin fairness and forwards the granted transaction to memory unchanged. It routes the memory response back to the granted requester only, and it sits between both cache controllers and the memory model or burst adapter.

## Interface
- ADDR_W, 32, byte address width
- LINE_W, 256, cache-line data width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset (low at a rising edge resets the block)
- i_read, i_write  in  1 each  I-cache memory read/write request
- i_address  in  ADDR_W  I-cache line address
- i_wdata  in  LINE_W  I-cache write line
- i_rdata  out  LINE_W  read line to I-cache
- i_resp  out  1  I-cache completion
- d_read, d_write, d_address, d_wdata, d_rdata, d_resp: same as the i_ ports, for the D-cache
- mem_read, mem_write  out  1 each  memory request
- mem_address  out  ADDR_W
- mem_wdata  out  LINE_W
- mem_rdata  in  LINE_W
- mem_resp  in  1  memory completion (one cycle per transaction)
- i_grant_cnt, d_grant_cnt  out  16 each  completed-transaction counters

## Operation
- The FSM has three states: IDLE, SERVE_I and SERVE_D.
- Per-requester request: req_x = x_read | x_write. Asserting read and write together is illegal; if it happens, both strobes are forwarded as-is.
- Registers:
  - state
  - last (1 bit, 0 = I, 1 = D): the most recently granted requester
  - mask_x (1 bit each): masks requester x in the first IDLE cycle after it completes
  - the two grant counters
- IDLE:
  - All mem_* outputs are 0.
  - Effective request: ereq_x = req_x & ~mask_x.
  - Only ereq_i → SERVE_I. Only ereq_d → SERVE_D.
  - Both asserted → grant the requester ≠ last.
  - Neither asserted → stay in IDLE.
  - Masks clear at the end of every IDLE cycle.
- SERVE_x:
  - mem_read, mem_write, mem_address and mem_wdata are combinationally driven from requester x.
  - x_resp = mem_resp. The other requester's resp = 0.
  - mem_rdata is broadcast to both i_rdata and d_rdata. It is valid only when the corresponding resp is high.
  - On mem_resp: go to IDLE, set mask_x, set last = x, and increment x_grant_cnt (wraps at 16'hFFFF → 0).
  - The grant holds until mem_resp, even if the requester drops its strobes. In that case the memory sees the dropped strobes; requesters must hold their request until resp.
- mem_resp arriving while in IDLE is ignored: no resp is delivered and no state changes.
- Reset (rst low at an edge):
  - state = IDLE, last = 1 (so the first tie goes to I), masks = 0, counters = 0.
  - All outputs read 0 from the following cycle.
  - A transaction in flight is abandoned; memory must be reset together with the arbiter.

## Timing
- Arbitration latency is one cycle. A request seen in IDLE at edge N makes mem_read/mem_write high in cycle N+1.
- Response path is combinational: mem_resp → x_resp in the same cycle, with no register.
- A requester must deassert its strobes in the cycle after its resp. The mask guarantees that a still-high stale strobe in that cycle is not re-granted.
- Back-to-back service:
  - resp at cycle R, IDLE at R+1.
  - The next grant is visible at R+2.
  - Minimum per-transaction overhead is 2 cycles beyond memory latency.
- Fairness: with both caches continuously requesting, grants strictly alternate I, D, I, D.
- No starvation: a waiting requester is served after at most one transaction of the other requester.

## Test plan
- **Reset values:** hold rst low for 2 cycles, then release. All outputs must be 0; i_grant_cnt = d_grant_cnt = 0; stay in IDLE with no requests.
- **Single I read:** i_read=1, i_address=0x0000_1000; memory responds after 5 cycles with rdata=256'hA5…A5.
  - mem_read is high from the cycle after the request, with mem_address=0x1000.
  - i_resp pulses 1 cycle with i_rdata=A5…A5; d_resp stays 0.
  - i_grant_cnt=1.
- **Simultaneous requests after reset:** assert i_read and d_write (d_address=0x2000, d_wdata=0x…BEEF) in the same cycle.
  - I is served first.
  - D is granted at R+2 with mem_write=1, mem_address=0x2000, mem_wdata=…BEEF.
  - Counters end at 1/1.
- **Continuous contention:** both caches re-request immediately after every resp, for 8 transactions. Grant order must be I,D,I,D,I,D,I,D.
- **Stale strobe and mask:** I holds i_read high for 1 cycle after i_resp, with d idle. No second I grant may start; i_grant_cnt increments once.
- **Reset mid-transaction:** assert rst low while in SERVE_D before mem_resp.
  - Next cycle: mem_read=mem_write=0, d_resp=0, counters=0.
  - After release, a pending d_read is granted normally.
